// File: rtl/matrix_loader_pkg.sv
// ---------------------------------------------------------------------------
// matrix_loader_pkg
// Shared types and helpers for the matrix stream loader and its register
// banks.
//   state_t    : loader FSM states (LOAD_A, LOAD_B, RUN)
//   elem_t     : one matrix element at the default element width
//   cnt_width  : row/col counter width for a given matrix order (min 1 bit)
// ---------------------------------------------------------------------------
package matrix_loader_pkg;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        RUN    = 2'd2
    } state_t;

    localparam int WIDTHX_DEFAULT = 4;

    typedef logic [WIDTHX_DEFAULT-1:0] elem_t;

    // $clog2(1) is 0, but a zero-width counter is not legal, so clamp to 1.
    function automatic int cnt_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage

// File: rtl/matrix_reg_bank.sv
// ---------------------------------------------------------------------------
// matrix_reg_bank
// SIZE x SIZE array of WIDTHx-bit registers with a single write port
// addressed by row/col. Cleared by reset, otherwise holds its contents.
// Ports:
//   clock, nreset : clock (rising edge), asynchronous active-low reset
//   we            : write enable
//   wr_row/wr_col : write address
//   wr_data       : element stored unchanged
//   mat           : whole array, [row][col]
// ---------------------------------------------------------------------------
module matrix_reg_bank
    import matrix_loader_pkg::*;
#(
    parameter int WIDTHx = WIDTHX_DEFAULT,
    parameter int SIZE   = 3,
    localparam int CW    = cnt_width(SIZE)
) (
    input  logic                                  clock,
    input  logic                                  nreset,
    input  logic                                  we,
    input  logic [CW-1:0]                         wr_row,
    input  logic [CW-1:0]                         wr_col,
    input  logic [WIDTHx-1:0]                     wr_data,
    output logic [SIZE-1:0][SIZE-1:0][WIDTHx-1:0] mat
);

    // Address decode by comparison keeps the index width independent of SIZE
    // (a SIZE=1 array has no address bits to index with).
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            mat <= '0;
        end else begin
            for (int r = 0; r < SIZE; r++) begin
                for (int c = 0; c < SIZE; c++) begin
                    if (we && (wr_row == CW'(r)) && (wr_col == CW'(c))) begin
                        mat[r][c] <= wr_data;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/matrix_stream_loader.sv
// ---------------------------------------------------------------------------
// matrix_stream_loader
// Collects a serial valid/ready stream of elements (A row-major, then B
// row-major) into two SIZE x SIZE register arrays, then raises mm_valid_o to
// the systolic multiplier and holds the arrays frozen until mm_ready_i.
// Optional framing check: define LOADER_LAST_CHECK_EN to add in_last/err_o.
// Ports:
//   clock, nreset        : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    : element stream handshake; in_data is the element
//   mm_valid_o           : job outstanding (high in RUN)
//   mm_ready_i           : multiplier finished, only honoured in RUN
//   a_matrix, b_matrix   : assembled operands, [row][col]
//   done_o               : one-cycle pulse after the job is released
//   busy_o               : loader holds a partial or complete job
//   in_last, err_o       : (LOADER_LAST_CHECK_EN) end-of-job marker, sticky
//                          framing error
// ---------------------------------------------------------------------------
module matrix_stream_loader
    import matrix_loader_pkg::*;
#(
    parameter int WIDTHx = WIDTHX_DEFAULT,
    parameter int SIZE   = 3
) (
    input  logic                                  clock,
    input  logic                                  nreset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [WIDTHx-1:0]                     in_data,
    output logic                                  mm_valid_o,
    input  logic                                  mm_ready_i,
    output logic [SIZE-1:0][SIZE-1:0][WIDTHx-1:0] a_matrix,
    output logic [SIZE-1:0][SIZE-1:0][WIDTHx-1:0] b_matrix,
    output logic                                  done_o,
    output logic                                  busy_o
`ifdef LOADER_LAST_CHECK_EN
    ,
    input  logic                                  in_last,
    output logic                                  err_o
`endif
);

    localparam int            CW   = cnt_width(SIZE);
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    state_t        state, next_state;
    logic [CW-1:0] row, col;
    logic          accept;
    logic          last_elem;
    logic          drop;
    logic          we_a, we_b;

    assign accept    = in_valid && in_ready;
    assign last_elem = (row == LAST) && (col == LAST);

`ifdef LOADER_LAST_CHECK_EN
    logic frame_err;

    // in_last belongs only on the final B element. Early in_last abandons the
    // job; a missing in_last on the final element is flagged but the job runs.
    assign drop      = accept && in_last && !((state == LOAD_B) && last_elem);
    assign frame_err = accept && ((state == LOAD_A) ? in_last
                                                    : (in_last != last_elem));

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            err_o <= 1'b0;
        end else if (frame_err) begin
            err_o <= 1'b1;
        end
    end
`else
    assign drop = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state <= LOAD_A;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            LOAD_A: begin
                if (accept && !drop && last_elem) next_state = LOAD_B;
            end
            LOAD_B: begin
                if (drop)                     next_state = LOAD_A;
                else if (accept && last_elem) next_state = RUN;
            end
            RUN: begin
                if (mm_ready_i) next_state = LOAD_A;
            end
            default: next_state = LOAD_A;
        endcase
    end

    // Outputs decoded from state. mm_valid_o comes straight off the state
    // register, so it rises with the edge that stores the last B element.
    always_comb begin
        in_ready   = (state != RUN);
        mm_valid_o = (state == RUN);
        busy_o     = (state != LOAD_A) || (row != '0) || (col != '0);
        we_a       = accept && !drop && (state == LOAD_A);
        we_b       = accept && !drop && (state == LOAD_B);
    end

    // Row/col write pointer, shared by both matrices.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (last_elem || drop) begin
                row <= '0;
                col <= '0;
            end else if (col == LAST) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end else if ((state == RUN) && mm_ready_i) begin
            row <= '0;
            col <= '0;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            done_o <= 1'b0;
        end else begin
            done_o <= (state == RUN) && mm_ready_i;
        end
    end

    matrix_reg_bank #(.WIDTHx(WIDTHx), .SIZE(SIZE)) u_bank_a (
        .clock   (clock),
        .nreset  (nreset),
        .we      (we_a),
        .wr_row  (row),
        .wr_col  (col),
        .wr_data (in_data),
        .mat     (a_matrix)
    );

    matrix_reg_bank #(.WIDTHx(WIDTHx), .SIZE(SIZE)) u_bank_b (
        .clock   (clock),
        .nreset  (nreset),
        .we      (we_b),
        .wr_row  (row),
        .wr_col  (col),
        .wr_data (in_data),
        .mat     (b_matrix)
    );

endmodule
